// File: rtl/rv32i_mc_ctrl_if.sv
// Instruction/data bus handshake between the RV32I multi-cycle controller and memory.
// The controller side uses the master modport; memory or the bench uses slave.
interface rv32i_mc_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, output dmem_req, output dmem_we,
                  input imem_ack, input dmem_ack);
  modport slave  (input imem_req, input dmem_req, input dmem_we,
                  output imem_ack, output dmem_ack);
endinterface

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing with
// datapath selects, bus handshakes, and trap generation including bus timeouts.
module rv32i_mc_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            instr,
  input  logic                   cmp_eq,
  input  logic                   cmp_lt,
  input  logic                   cmp_ltu,
  rv32i_mc_ctrl_if.master        bus,
  output logic                   ir_we,
  output logic                   pc_we,
  output logic [1:0]             pc_sel,
  output logic [1:0]             alu_a_sel,
  output logic                   alu_b_sel,
  output logic [3:0]             alu_op,
  output logic [2:0]             imm_sel,
  output logic                   rf_we,
  output logic [1:0]             wb_sel,
  output logic                   trap,
  output logic [3:0]             trap_cause
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
  typedef enum logic [3:0] {K_ILL, K_OP, K_OPIMM, K_LOAD, K_STORE, K_BRANCH, K_LUI,
                            K_AUIPC, K_JAL, K_JALR, K_FENCE, K_ECALL, K_EBREAK} kind_e;

  localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      cause_q, cause_d;

  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_zero, expired, taken;
  kind_e      kind;
  logic [3:0] dp_op;
  logic [1:0] dp_a;
  logic       dp_b;
  logic [2:0] dp_imm;

  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign rd_zero = (instr[11:7] == 5'd0);
  assign expired = (TIMEOUT != 0) && (cnt_q == LAST);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    kind = K_ILL;
    case (instr[6:0])
      7'b0110011: if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    kind = K_OP;
      7'b0010011: begin
        if (funct3 == 3'b001) begin
          if (funct7 == 7'h00) kind = K_OPIMM;
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'h00 || funct7 == 7'h20) kind = K_OPIMM;
        end else begin
          kind = K_OPIMM;
        end
      end
      7'b0000011: if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) kind = K_LOAD;
      7'b0100011: if (funct3 <= 3'b010) kind = K_STORE;
      7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011) kind = K_BRANCH;
      7'b0110111: kind = K_LUI;
      7'b0010111: kind = K_AUIPC;
      7'b1101111: kind = K_JAL;
      7'b1100111: if (funct3 == 3'b000) kind = K_JALR;
      7'b0001111: if (funct3 == 3'b000) kind = K_FENCE;
      7'b1110011: begin
        if (instr == 32'h0000_0073)      kind = K_ECALL;
        else if (instr == 32'h0010_0073) kind = K_EBREAK;
      end
      default: kind = K_ILL;
    endcase
  end

  // Operand and immediate selection; shifts keep funct7[5] to tell SRLI from SRAI.
  always_comb begin
    dp_op  = 4'b0000;
    dp_a   = 2'd0;
    dp_b   = 1'b0;
    dp_imm = 3'd0;
    case (kind)
      K_OP:     dp_op = {funct7[5], funct3};
      K_OPIMM:  begin
        dp_op = (funct3[1:0] == 2'b01) ? {funct7[5], funct3} : {1'b0, funct3};
        dp_b  = 1'b1;
      end
      K_LOAD:   dp_b = 1'b1;
      K_STORE:  begin dp_b = 1'b1; dp_imm = 3'd1; end
      K_BRANCH: dp_imm = 3'd2;
      K_LUI:    begin dp_a = 2'd2; dp_b = 1'b1; dp_imm = 3'd3; end
      K_AUIPC:  begin dp_a = 2'd1; dp_b = 1'b1; dp_imm = 3'd3; end
      K_JAL:    begin dp_a = 2'd1; dp_b = 1'b1; dp_imm = 3'd4; end
      K_JALR:   dp_b = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = cmp_eq;
      3'b001:  taken = !cmp_eq;
      3'b100:  taken = cmp_lt;
      3'b101:  taken = !cmp_lt;
      3'b110:  taken = cmp_ltu;
      3'b111:  taken = !cmp_ltu;
      default: taken = 1'b0;
    endcase
  end

  // rst_n gates the outputs combinationally so they drop the moment reset asserts.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    cause_d      = cause_q;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 1'b0;
    alu_op       = 4'd0;
    imm_sel      = 3'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    trap         = 1'b0;
    trap_cause   = 4'd0;
    if (rst_n) begin
      if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        alu_op    = dp_op;
        alu_a_sel = dp_a;
        alu_b_sel = dp_b;
        imm_sel   = dp_imm;
      end
      case (state_q)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          if (bus.imem_ack) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else if (expired) begin
            state_d = S_TRAP;
            cause_d = 4'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DECODE: begin
          state_d = S_EXEC;
          case (kind)
            K_ILL:    begin state_d = S_TRAP; cause_d = 4'd2;  end
            K_ECALL:  begin state_d = S_TRAP; cause_d = 4'd11; end
            K_EBREAK: begin state_d = S_TRAP; cause_d = 4'd3;  end
            default:  ;
          endcase
        end
        S_EXEC: begin
          if (kind == K_BRANCH) begin
            pc_we   = 1'b1;
            pc_sel  = {1'b0, taken};
            state_d = S_FETCH;
          end else if (kind == K_LOAD || kind == K_STORE) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = (kind == K_STORE);
          if (bus.dmem_ack) begin
            if (kind == K_STORE) begin
              pc_we   = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (expired) begin
            state_d = S_TRAP;
            cause_d = (kind == K_STORE) ? 4'd7 : 4'd5;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WB: begin
          rf_we   = !rd_zero && (kind != K_FENCE);
          wb_sel  = (kind == K_LOAD) ? 2'd1 : (kind == K_JAL || kind == K_JALR) ? 2'd2 : 2'd0;
          pc_we   = 1'b1;
          pc_sel  = (kind == K_JAL) ? 2'd1 : (kind == K_JALR) ? 2'd2 : 2'd0;
          state_d = S_FETCH;
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_q;
          pc_we      = 1'b1;
          pc_sel     = 2'd3;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Bench for rv32i_mc_ctrl: an instruction-level model expands each instruction into
// the expected per-cycle control trace, which is compared against the DUT each cycle.
module tb_rv32i_mc_ctrl;
  localparam int TO = 4;

  typedef enum {C_ILL, C_R, C_I, C_SH, C_LD, C_ST, C_BR, C_LUI, C_AUIPC,
                C_JAL, C_JALR, C_FENCE, C_ECALL, C_EBREAK} cls_t;

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [3:0] alu_op;
    logic [2:0] imm_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       trap;
    logic [3:0] trap_cause;
  } outs_t;

  typedef struct packed {
    logic  iack, dack;
    outs_t exp, msk;
  } step_t;

  localparam logic [6:0] OPCS [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                                       7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73, 7'h13};

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] instr;
  logic cmp_eq, cmp_lt, cmp_ltu;
  logic ir_we, pc_we, alu_b_sel, rf_we, trap;
  logic [1:0] pc_sel, alu_a_sel, wb_sel;
  logic [3:0] alu_op, trap_cause;
  logic [2:0] imm_sel;
  outs_t obs;
  step_t q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rv32i_mc_ctrl_if bus ();

  rv32i_mc_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
    .bus(bus),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .imm_sel(imm_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .trap(trap), .trap_cause(trap_cause)
  );

  always_comb obs = {bus.imem_req, bus.dmem_req, bus.dmem_we, ir_we, pc_we, pc_sel,
                     alu_a_sel, alu_b_sel, alu_op, imm_sel, rf_we, wb_sel, trap, trap_cause};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want)
      else begin bad++; $error("FAIL %s got=%h want=%h", tag, got, want); end
  endtask

  function automatic cls_t classify(input logic [31:0] i);
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    case (i[6:0])
      7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) ? C_R : C_ILL;
      7'h13: if (f3 == 1) return (f7 == 7'h00) ? C_SH : C_ILL;
             else if (f3 == 5) return (f7 == 7'h00 || f7 == 7'h20) ? C_SH : C_ILL;
             else return C_I;
      7'h03: return (f3 inside {0, 1, 2, 4, 5}) ? C_LD : C_ILL;
      7'h23: return (f3 inside {0, 1, 2}) ? C_ST : C_ILL;
      7'h63: return (f3 inside {0, 1, 4, 5, 6, 7}) ? C_BR : C_ILL;
      7'h37: return C_LUI;
      7'h17: return C_AUIPC;
      7'h6F: return C_JAL;
      7'h67: return (f3 == 0) ? C_JALR : C_ILL;
      7'h0F: return (f3 == 0) ? C_FENCE : C_ILL;
      7'h73: return (i == 32'h73) ? C_ECALL : (i == 32'h0010_0073) ? C_EBREAK : C_ILL;
      default: return C_ILL;
    endcase
  endfunction

  function automatic step_t base(input logic ia, input logic da);
    step_t s = '0;
    s.iack = ia;
    s.dack = da;
    s.msk.imem_req = 1'b1; s.msk.dmem_req = 1'b1; s.msk.ir_we = 1'b1;
    s.msk.pc_we = 1'b1;    s.msk.rf_we = 1'b1;    s.msk.trap = 1'b1;
    return s;
  endfunction

  // Adds the datapath-select expectations for an instruction class.
  function automatic step_t dp(input step_t s_in, input cls_t c, input logic [31:0] i, input bit alu);
    step_t s = s_in;
    s.msk.imm_sel = '1;
    case (c)
      C_I, C_SH, C_LD, C_JALR: s.exp.imm_sel = 3'd0;
      C_ST:                    s.exp.imm_sel = 3'd1;
      C_BR:                    s.exp.imm_sel = 3'd2;
      C_LUI, C_AUIPC:          s.exp.imm_sel = 3'd3;
      C_JAL:                   s.exp.imm_sel = 3'd4;
      default:                 s.msk.imm_sel = '0;
    endcase
    if (alu && c inside {C_R, C_I, C_SH, C_LD, C_ST, C_LUI, C_AUIPC, C_JAL, C_JALR}) begin
      s.msk.alu_op = '1;
      s.exp.alu_op = (c == C_R || c == C_SH) ? {i[30], i[14:12]} :
                     (c == C_I) ? {1'b0, i[14:12]} : 4'd0;
      if (!(c inside {C_JAL, C_JALR})) begin
        s.msk.alu_a_sel = '1;
        s.msk.alu_b_sel = 1'b1;
        s.exp.alu_a_sel = (c == C_LUI) ? 2'd2 : (c == C_AUIPC) ? 2'd1 : 2'd0;
        s.exp.alu_b_sel = (c != C_R);
      end
    end
    return s;
  endfunction

  task automatic push_trap(input logic [3:0] cause);
    step_t s = base(1'b0, 1'b0);
    s.exp.trap = 1'b1;  s.exp.trap_cause = cause; s.msk.trap_cause = '1;
    s.exp.pc_we = 1'b1; s.exp.pc_sel = 2'd3;      s.msk.pc_sel = '1;
    q.push_back(s);
  endtask

  // Expected cycle-by-cycle trace of one instruction given operands and ack delays.
  task automatic build(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input int id, input int dd);
    step_t s;
    cls_t c;
    logic tk;
    q.delete();
    for (int k = 0; k < TO; k++) begin
      s = base(k == id, 1'b0);
      s.exp.imem_req = 1'b1;
      s.exp.ir_we = (k == id);
      q.push_back(s);
      if (k == id) break;
    end
    if (id >= TO) begin push_trap(4'd1); return; end
    c = classify(i);
    q.push_back(dp(base(1'b0, 1'b0), c, i, 1'b0));
    if (c == C_ILL)    begin push_trap(4'd2);  return; end
    if (c == C_ECALL)  begin push_trap(4'd11); return; end
    if (c == C_EBREAK) begin push_trap(4'd3);  return; end
    s = dp(base(1'b0, 1'b0), c, i, 1'b1);
    if (c == C_BR) begin
      case (i[14:12])
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = ($signed(a) < $signed(b));
        3'd5: tk = ($signed(a) >= $signed(b));
        3'd6: tk = (a < b);
        default: tk = (a >= b);
      endcase
      s.exp.pc_we = 1'b1; s.exp.pc_sel = {1'b0, tk}; s.msk.pc_sel = '1;
      q.push_back(s);
      return;
    end
    q.push_back(s);
    if (c == C_LD || c == C_ST) begin
      for (int k = 0; k < TO; k++) begin
        s = dp(base(1'b0, k == dd), c, i, 1'b1);
        s.exp.dmem_req = 1'b1; s.exp.dmem_we = (c == C_ST); s.msk.dmem_we = 1'b1;
        if (k == dd && c == C_ST) begin
          s.exp.pc_we = 1'b1; s.exp.pc_sel = 2'd0; s.msk.pc_sel = '1;
        end
        q.push_back(s);
        if (k == dd) break;
      end
      if (dd >= TO) begin push_trap((c == C_ST) ? 4'd7 : 4'd5); return; end
      if (c == C_ST) return;
    end
    s = dp(base(1'b0, 1'b0), c, i, 1'b1);
    s.exp.rf_we = (i[11:7] != 5'd0) && (c != C_FENCE);
    if (s.exp.rf_we) begin
      s.msk.wb_sel = '1;
      s.exp.wb_sel = (c == C_LD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
    end
    s.exp.pc_we = 1'b1; s.msk.pc_sel = '1;
    s.exp.pc_sel = (c == C_JAL) ? 2'd1 : (c == C_JALR) ? 2'd2 : 2'd0;
    q.push_back(s);
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 back in FETCH.
  task automatic run(input string name, input logic [31:0] i, input logic [31:0] a,
                     input logic [31:0] b, input int id, input int dd);
    build(i, a, b, id, dd);
    instr = i;
    cmp_eq = (a == b);
    cmp_lt = ($signed(a) < $signed(b));
    cmp_ltu = (a < b);
    for (int n = 0; n < q.size(); n++) begin
      bus.imem_ack = q[n].iack;
      bus.dmem_ack = q[n].dack;
      @(negedge clk);
      check($sformatf("%s_c%0d", name, n), 32'(obs & q[n].msk), 32'(q[n].exp & q[n].msk));
      @(posedge clk);
      #1;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0] opc = OPCS[$urandom_range(0, 11)];
    logic [6:0] f7;
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if ($urandom_range(0, 15) == 0) return r;
    if (opc == 7'h73)
      case ($urandom_range(0, 2))
        0:       return 32'h0000_0073;
        1:       return 32'h0010_0073;
        default: return {r[31:7], opc};
      endcase
    return {f7, r[24:7], opc};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int id, dd;
    logic [31:0] a, b;
    rst_n = 1'b0;
    instr = 32'h0;
    cmp_eq = 1'b0; cmp_lt = 1'b0; cmp_ltu = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    #3;
    check("reset_outs", 32'(obs), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("first_imem_req", 32'(bus.imem_req), 32'h1);

    run("add",     32'h0020_81B3, 32'd1, 32'd2, 0, 0);
    run("beq_t",   32'h0000_0463, 32'd5, 32'd5, 0, 0);
    run("beq_n",   32'h0000_0463, 32'd5, 32'd6, 0, 0);
    run("lw_d3",   32'h0000_2283, 32'd0, 32'd0, 0, 3);
    run("sw",      32'h0050_2223, 32'd0, 32'd0, 0, 0);
    run("ecall",   32'h0000_0073, 32'd0, 32'd0, 0, 0);
    run("ebreak",  32'h0010_0073, 32'd0, 32'd0, 0, 0);
    run("illegal", 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 0);
    run("addi_x0", 32'h0000_0013, 32'd0, 32'd0, 0, 0);
    run("fence",   32'h0000_000F, 32'd0, 32'd0, 0, 0);
    run("fence_i", 32'h0000_100F, 32'd0, 32'd0, 0, 0);
    run("csrrw",   32'h3052_9073, 32'd0, 32'd0, 0, 0);
    run("jal",     32'h0080_00EF, 32'd0, 32'd0, 0, 0);
    run("jalr",    32'h0000_80E7, 32'd0, 32'd0, 0, 0);
    run("lui",     32'h1234_52B7, 32'd0, 32'd0, 0, 0);
    run("auipc",   32'h0000_1297, 32'd0, 32'd0, 0, 0);
    run("srai",    32'h4010_D093, 32'd0, 32'd0, 0, 0);
    run("blt",     32'h0020_C463, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run("bltu",    32'h0020_E463, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run("if_to",   32'h0020_81B3, 32'd0, 32'd0, 99, 0);
    run("if_last", 32'h0020_81B3, 32'd0, 32'd0, 3, 0);
    run("lw_to",   32'h0000_2283, 32'd0, 32'd0, 1, 99);
    run("sw_to",   32'h0050_2223, 32'd0, 32'd0, 0, 99);

    // Reset in the middle of a load's MEM wait.
    instr = 32'h0000_2283;
    bus.imem_ack = 1'b1;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("mem_req_before_rst", 32'(bus.dmem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mem_req_in_rst", 32'(bus.dmem_req), 32'h0);
    check("outs_in_rst", 32'(obs), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("imem_req_after_rst", 32'(bus.imem_req), 32'h1);

    for (int n = 0; n < 250; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      id = ($urandom_range(0, 7) < 5) ? 0 : int'($urandom_range(1, 5));
      dd = ($urandom_range(0, 7) < 5) ? 0 : int'($urandom_range(1, 5));
      run($sformatf("rnd%0d", n), rand_instr(), a, b, id, dd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
